// File: rtl/pmu_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pmu_cfg_pkg
//  Purpose  : Shared definitions for the AD5522 PMU command sequencer.
//             Holds the FSM state encoding, the command FIFO entry layout
//             and the default frame width.
//  Ports    : none (package)
//  Options  : none
//  Revision : 1.0  initial release
// ============================================================================
package pmu_cfg_pkg;

   // Default AD5522 frame width
   localparam int PMU_CFG_DW_DEFAULT = 29;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_WR = 3'd2,
      ST_WAIT_RD = 3'd3,
      ST_GAP     = 3'd4
   } seq_state_t;

   // A FIFO entry is {op_rd, frame}: the op bit (1 = readback) is the MSB,
   // directly above the frame word.
   function automatic int entry_width(input int dw);
      return dw + 1;
   endfunction

   function automatic int entry_op_bit(input int dw);
      return dw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pmu_cfg_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pmu_cfg_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO for sequencer commands.
//             dout always shows the head entry while empty is low.
//  Ports    : clk, rst         clock and synchronous active-high reset
//             push, din        write an entry (ignored while full)
//             pop              consume the head entry (ignored while empty)
//             flush            discard every entry in one cycle; a push or
//                              pop in the same cycle is dropped
//             full, empty      occupancy flags
//             dout             head entry
//  Options  : none
//  Revision : 1.0  initial release
// ============================================================================
module pmu_cfg_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit separates the full and empty cases
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/pmu_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pmu_cfg_seq
//  Purpose  : Command sequencer in front of the AD5522 PMU SPI driver.
//             Queues write/readback commands, issues them one at a time on
//             the driver's req/done handshake, enforces an inter-frame gap,
//             returns readback words and flags transactions that time out.
//  Ports    : clk, rst                 clock, synchronous active-high reset
//             cmd_vld/cmd_rdy          command push handshake
//             cmd_rd, cmd_data         1 = readback, frame word
//             cmd_flush                drop all queued commands
//             rd_data, rd_data_vld     readback word and 1-cycle valid
//             seq_busy                 FSM active or commands queued
//             err_timeout, err_clear   sticky timeout flag and its clear
//             ad5522_rst_busy          device calibration in progress
//             pmu_cfg_wr_req/rd_req    1-cycle requests to the driver
//             pmu_cfg_wr_data          frame word for the driver
//             pmu_cfg_wr_done/rd_done  driver completion strobes
//             pmu_cmp_result(_vld)     driver readback word
//             stat_*_cnt               saturating counters (option only)
//  Options  : PMU_CFG_STAT_EN adds stat_wr_cnt, stat_rd_cnt, stat_to_cnt
//  Revision : 1.0  initial release
// ============================================================================
module pmu_cfg_seq
   import pmu_cfg_pkg::*;
#(
   parameter int PMU_CFG_DW  = PMU_CFG_DW_DEFAULT,
   parameter int FIFO_DEPTH  = 16,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 2000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_vld,
   output logic                  cmd_rdy,
   input  logic                  cmd_rd,
   input  logic [PMU_CFG_DW-1:0] cmd_data,
   input  logic                  cmd_flush,
   output logic [PMU_CFG_DW-1:0] rd_data,
   output logic                  rd_data_vld,
   output logic                  seq_busy,
   output logic                  err_timeout,
   input  logic                  err_clear,
   input  logic                  ad5522_rst_busy,
   output logic                  pmu_cfg_wr_req,
   output logic                  pmu_cfg_rd_req,
   output logic [PMU_CFG_DW-1:0] pmu_cfg_wr_data,
   input  logic                  pmu_cfg_wr_done,
   input  logic                  pmu_cfg_rd_done,
   input  logic [PMU_CFG_DW-1:0] pmu_cmp_result,
   input  logic                  pmu_cmp_result_vld
`ifdef PMU_CFG_STAT_EN
   ,
   output logic [15:0]           stat_wr_cnt,
   output logic [15:0]           stat_rd_cnt,
   output logic [15:0]           stat_to_cnt
`endif
);

   localparam int ENTRY_W = entry_width(PMU_CFG_DW);
   localparam int OP_BIT  = entry_op_bit(PMU_CFG_DW);
   localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W   = $clog2(GAP_CYC + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   seq_state_t                state;
   seq_state_t                state_nxt;

   logic                      fifo_push;
   logic                      fifo_pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [ENTRY_W-1:0]        fifo_din;
   logic [ENTRY_W-1:0]        fifo_dout;

   logic                      op_rd;
   logic [TO_W-1:0]           to_cnt;
   logic [GAP_W-1:0]          gap_cnt;
   logic                      rd_done_seen;
   logic                      res_seen;
   logic [PMU_CFG_DW-1:0]     res_q;
   logic                      rd_done_any;
   logic                      res_any;
   logic                      rd_complete;
   logic                      timeout_hit;

   // ------------------------------------------------------------------
   // Command FIFO
   // ------------------------------------------------------------------
   assign fifo_din  = {cmd_rd, cmd_data};
   // A push coinciding with a flush is discarded
   assign fifo_push = cmd_vld && !fifo_full && !cmd_flush;
   assign cmd_rdy   = !fifo_full;

   pmu_cfg_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (cmd_flush),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   assign seq_busy = (state != ST_IDLE) || !fifo_empty;

   // Readback completes once both strobes have been seen, counting the
   // ones arriving this cycle
   assign rd_done_any = rd_done_seen || pmu_cfg_rd_done;
   assign res_any     = res_seen || pmu_cmp_result_vld;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      fifo_pop       = 1'b0;
      pmu_cfg_wr_req = 1'b0;
      pmu_cfg_rd_req = 1'b0;
      rd_complete    = 1'b0;
      timeout_hit    = 1'b0;
      case (state)
         ST_IDLE: begin
            // No pop during a flush: the head entry is being discarded
            if (!fifo_empty && !ad5522_rst_busy && !cmd_flush) begin
               fifo_pop  = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            pmu_cfg_wr_req = !op_rd;
            pmu_cfg_rd_req = op_rd;
            state_nxt      = op_rd ? ST_WAIT_RD : ST_WAIT_WR;
         end
         ST_WAIT_WR: begin
            // Completion takes priority over a same-cycle timeout
            if (pmu_cfg_wr_done) begin
               state_nxt = ST_GAP;
            end else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_GAP;
            end
         end
         ST_WAIT_RD: begin
            if (rd_done_any && res_any) begin
               rd_complete = 1'b1;
               state_nxt   = ST_GAP;
            end else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pmu_cfg_wr_data <= '0;
         op_rd           <= 1'b0;
         to_cnt          <= '0;
         gap_cnt         <= '0;
         rd_done_seen    <= 1'b0;
         res_seen        <= 1'b0;
         res_q           <= '0;
         rd_data         <= '0;
         rd_data_vld     <= 1'b0;
         err_timeout     <= 1'b0;
      end else begin
         rd_data_vld <= rd_complete;

         // The frame word moves only on a pop, so it stays stable for the
         // whole transaction and through the following gap
         if (fifo_pop) begin
            pmu_cfg_wr_data <= fifo_dout[PMU_CFG_DW-1:0];
            op_rd           <= fifo_dout[OP_BIT];
         end

         if (state == ST_ISSUE)
            to_cnt <= '0;
         else if (state == ST_WAIT_WR || state == ST_WAIT_RD)
            to_cnt <= to_cnt + 1'b1;

         if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
         else                 gap_cnt <= '0;

         if (state == ST_ISSUE) begin
            rd_done_seen <= 1'b0;
            res_seen     <= 1'b0;
         end else if (state == ST_WAIT_RD) begin
            if (pmu_cfg_rd_done) rd_done_seen <= 1'b1;
            if (pmu_cmp_result_vld) begin
               res_seen <= 1'b1;
               res_q    <= pmu_cmp_result;
            end
         end

         // A result arriving together with completion bypasses res_q
         if (rd_complete)
            rd_data <= pmu_cmp_result_vld ? pmu_cmp_result : res_q;

         // Sticky; a new timeout beats a simultaneous clear
         if (timeout_hit)    err_timeout <= 1'b1;
         else if (err_clear) err_timeout <= 1'b0;
      end
   end

`ifdef PMU_CFG_STAT_EN
   // ------------------------------------------------------------------
   // Saturating transaction statistics
   // ------------------------------------------------------------------
   logic wr_ok;
   assign wr_ok = (state == ST_WAIT_WR) && pmu_cfg_wr_done;

   always_ff @(posedge clk) begin
      if (rst || err_clear) begin
         stat_wr_cnt <= '0;
         stat_rd_cnt <= '0;
         stat_to_cnt <= '0;
      end else begin
         if (wr_ok && stat_wr_cnt != 16'hFFFF)       stat_wr_cnt <= stat_wr_cnt + 1'b1;
         if (rd_complete && stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 1'b1;
         if (timeout_hit && stat_to_cnt != 16'hFFFF) stat_to_cnt <= stat_to_cnt + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmu_cfg_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmu_cfg_seq
//  Purpose  : Directed self-checking bench for pmu_cfg_seq. Inputs change
//             and outputs are sampled on the falling clock edge.
//  Options  : PMU_CFG_STAT_EN connects the statistics outputs when defined
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmu_cfg_seq;

   localparam int DW    = 29;
   localparam int DEPTH = 16;
   localparam int GAP   = 4;
   localparam int TO    = 40;
   localparam int BOUND = 200;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_vld = 1'b0;
   logic          cmd_rdy;
   logic          cmd_rd = 1'b0;
   logic [DW-1:0] cmd_data = '0;
   logic          cmd_flush = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_data_vld;
   logic          seq_busy;
   logic          err_timeout;
   logic          err_clear = 1'b0;
   logic          ad5522_rst_busy = 1'b0;
   logic          wr_req;
   logic          rd_req;
   logic [DW-1:0] wr_data;
   logic          wr_done = 1'b0;
   logic          rd_done = 1'b0;
   logic [DW-1:0] cmp_result = '0;
   logic          cmp_vld = 1'b0;
`ifdef PMU_CFG_STAT_EN
   logic [15:0]   stat_wr_cnt;
   logic [15:0]   stat_rd_cnt;
   logic [15:0]   stat_to_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int req_cnt     = 0;
   int vld_cnt     = 0;

   always #5 clk = ~clk;

   pmu_cfg_seq #(
      .PMU_CFG_DW  (DW),
      .FIFO_DEPTH  (DEPTH),
      .GAP_CYC     (GAP),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .cmd_vld            (cmd_vld),
      .cmd_rdy            (cmd_rdy),
      .cmd_rd             (cmd_rd),
      .cmd_data           (cmd_data),
      .cmd_flush          (cmd_flush),
      .rd_data            (rd_data),
      .rd_data_vld        (rd_data_vld),
      .seq_busy           (seq_busy),
      .err_timeout        (err_timeout),
      .err_clear          (err_clear),
      .ad5522_rst_busy    (ad5522_rst_busy),
      .pmu_cfg_wr_req     (wr_req),
      .pmu_cfg_rd_req     (rd_req),
      .pmu_cfg_wr_data    (wr_data),
      .pmu_cfg_wr_done    (wr_done),
      .pmu_cfg_rd_done    (rd_done),
      .pmu_cmp_result     (cmp_result),
      .pmu_cmp_result_vld (cmp_vld)
`ifdef PMU_CFG_STAT_EN
      ,
      .stat_wr_cnt        (stat_wr_cnt),
      .stat_rd_cnt        (stat_rd_cnt),
      .stat_to_cnt        (stat_to_cnt)
`endif
   );

   // Count request pulses and readback strobes as they are presented
   always @(negedge clk) begin
      if (wr_req || rd_req) req_cnt++;
      if (rd_data_vld)      vld_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic rd, input logic [DW-1:0] data);
      cmd_vld  = 1'b1;
      cmd_rd   = rd;
      cmd_data = data;
      step(1);
      cmd_vld  = 1'b0;
   endtask

   // Steps until a request is visible; n is the number of steps taken
   task automatic wait_req(output int n, input string tag);
      n = 0;
      while (!(wr_req || rd_req) && n < BOUND) begin
         step(1);
         n++;
      end
      chk(tag, 64'(n < BOUND), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;

      // ---------------- reset state ----------------
      step(3);
      chk("rst_cmd_rdy",     64'(cmd_rdy),     64'd1);
      chk("rst_wr_req",      64'(wr_req),      64'd0);
      chk("rst_rd_req",      64'(rd_req),      64'd0);
      chk("rst_seq_busy",    64'(seq_busy),    64'd0);
      chk("rst_rd_data_vld", 64'(rd_data_vld), 64'd0);
      chk("rst_err_timeout", 64'(err_timeout), 64'd0);
      chk("rst_wr_data",     64'(wr_data),     64'd0);
      rst = 1'b0;

      // ---------------- write held off by calibration ----------------
      ad5522_rst_busy = 1'b1;
      base = req_cnt;
      push(1'b0, 29'h0A5A5A5);
      push(1'b0, 29'h0000001);
      step(8);
      chk("busy_no_req",   64'(req_cnt - base), 64'd0);
      chk("busy_seq_busy", 64'(seq_busy),       64'd1);
      ad5522_rst_busy = 1'b0;
      step(1);
      chk("t1_wr_req",  64'(wr_req),  64'd1);
      chk("t1_rd_req",  64'(rd_req),  64'd0);
      chk("t1_wr_data", 64'(wr_data), 64'h0A5A5A5);
      step(1);
      chk("t1_req_pulse", 64'(wr_req), 64'd0);
      wr_done = 1'b1; step(1); wr_done = 1'b0;
      wait_req(n, "t1_next_req");
      chk("t1_gap_len",   64'(n),       64'(GAP + 1));
      chk("t1_wr_data2",  64'(wr_data), 64'h0000001);
      step(1);
      wr_done = 1'b1; step(1); wr_done = 1'b0;
      step(8);

      // ---------------- readback, result before done ----------------
      push(1'b1, 29'h1000000);
      chk("t2_no_req_n1", 64'(rd_req), 64'd0);
      step(1);
      chk("t2_rd_req_n2", 64'(rd_req),  64'd1);
      chk("t2_wr_req",    64'(wr_req),  64'd0);
      chk("t2_frame",     64'(wr_data), 64'h1000000);
      step(1);
      cmp_result = 29'h0400123; cmp_vld = 1'b1;
      step(1);
      cmp_vld = 1'b0; cmp_result = 29'h1FFFFFFF;
      step(1);
      rd_done = 1'b1;
      chk("t2_vld_early", 64'(rd_data_vld), 64'd0);
      step(1);
      rd_done = 1'b0;
      chk("t2_rd_vld",  64'(rd_data_vld), 64'd1);
      chk("t2_rd_data", 64'(rd_data),     64'h0400123);
      step(1);
      chk("t2_vld_pulse", 64'(rd_data_vld), 64'd0);
      step(8);

      // ---------------- readback, result and done together ----------------
      push(1'b1, 29'h1000001);
      step(1);
      chk("t2b_rd_req", 64'(rd_req), 64'd1);
      step(1);
      cmp_result = 29'h0ABCDEF; cmp_vld = 1'b1; rd_done = 1'b1;
      step(1);
      cmp_vld = 1'b0; rd_done = 1'b0; cmp_result = '0;
      chk("t2b_rd_vld",  64'(rd_data_vld), 64'd1);
      chk("t2b_rd_data", 64'(rd_data),     64'h0ABCDEF);
      step(8);

      // ---------------- FIFO full ----------------
      ad5522_rst_busy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         chk("t3_cmd_rdy", 64'(cmd_rdy), (i < 16) ? 64'd1 : 64'd0);
         push(1'b0, DW'(32'h100 + i));
      end
      ad5522_rst_busy = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wait_req(n, "t3_req");
         chk("t3_order", 64'(wr_data), 64'(32'h100 + i));
         step(1);
         wr_done = 1'b1; step(1); wr_done = 1'b0;
      end
      base = req_cnt;
      step(20);
      chk("t3_no_17th", 64'(req_cnt - base), 64'd0);
      chk("t3_idle",    64'(seq_busy),       64'd0);

      // ---------------- timeouts ----------------
      ad5522_rst_busy = 1'b1;
      push(1'b0, 29'h0000AAA);
      push(1'b0, 29'h0000BBB);
      push(1'b0, 29'h0000CCC);
      ad5522_rst_busy = 1'b0;
      wait_req(n, "t4_a_req");
      chk("t4_a_data", 64'(wr_data), 64'h0000AAA);
      step(TO);
      chk("t4_err_before", 64'(err_timeout), 64'd0);
      step(1);
      chk("t4_err_set", 64'(err_timeout), 64'd1);
      wait_req(n, "t4_b_req");
      chk("t4_b_after_gap", 64'(n),       64'(GAP + 1));
      chk("t4_b_data",      64'(wr_data), 64'h0000BBB);
      step(2);
      err_clear = 1'b1; step(1); err_clear = 1'b0;
      chk("t4_err_clear", 64'(err_timeout), 64'd0);
      step(TO - 3);
      err_clear = 1'b1; step(1); err_clear = 1'b0;
      chk("t4_set_wins", 64'(err_timeout), 64'd1);
      err_clear = 1'b1; step(1); err_clear = 1'b0;
      chk("t4_err_clear2", 64'(err_timeout), 64'd0);
      wait_req(n, "t4_c_req");
      chk("t4_c_data", 64'(wr_data), 64'h0000CCC);
      step(TO);
      wr_done = 1'b1; step(1); wr_done = 1'b0;
      chk("t4_done_at_limit", 64'(err_timeout), 64'd0);
      step(8);

      // ---------------- flush during a write ----------------
      base = req_cnt;
      for (int i = 0; i < 5; i++) push(1'b0, DW'(32'h500 + i));
      chk("t5_inflight", 64'(wr_data), 64'h500);
      cmd_flush = 1'b1; cmd_vld = 1'b1; cmd_data = 29'h00005FF;
      step(1);
      cmd_flush = 1'b0; cmd_vld = 1'b0;
      chk("t5_busy_inflight", 64'(seq_busy), 64'd1);
      wr_done = 1'b1; step(1); wr_done = 1'b0;
      step(3);
      chk("t5_busy_gap", 64'(seq_busy), 64'd1);
      step(1);
      chk("t5_busy_fell", 64'(seq_busy), 64'd0);
      step(20);
      chk("t5_req_count", 64'(req_cnt - base), 64'd1);

      // ---------------- reset during a readback ----------------
      push(1'b1, 29'h1000002);
      step(1);
      chk("t6_rd_req", 64'(rd_req), 64'd1);
      step(1);
      cmp_result = 29'h0777777; cmp_vld = 1'b1;
      step(1);
      cmp_vld = 1'b0;
      base = vld_cnt;
      rst = 1'b1; rd_done = 1'b1;
      step(1);
      rst = 1'b0; rd_done = 1'b0;
      chk("t6_cmd_rdy",     64'(cmd_rdy),     64'd1);
      chk("t6_wr_req",      64'(wr_req),      64'd0);
      chk("t6_rd_req",      64'(rd_req),      64'd0);
      chk("t6_seq_busy",    64'(seq_busy),    64'd0);
      chk("t6_rd_data_vld", 64'(rd_data_vld), 64'd0);
      chk("t6_rd_data",     64'(rd_data),     64'd0);
      chk("t6_err_timeout", 64'(err_timeout), 64'd0);
      chk("t6_wr_data",     64'(wr_data),     64'd0);
      step(5);
      chk("t6_no_vld", 64'(vld_cnt - base), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pmu_cfg_seq.md
Name: pmu_cfg_seq

Overview:
Command sequencer directly upstream of the AD5522 PMU SPI driver. Buffers write/readback commands from the PS register bank in a small FIFO. Issues them one at a time on the driver's wr_req/rd_req handshake and enforces a minimum inter-frame gap. Returns readback words to the register bank and flags transactions that the driver never completes.

Parameters:
PMU_CFG_DW, 29, AD5522 frame width
FIFO_DEPTH, 16, command FIFO depth (power of 2)
GAP_CYC, 4, idle clk cycles between a done and the next req (min 1)
TIMEOUT_CYC, 2000, clk cycles allowed from req to completion (20 us @100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
cmd_vld  in  1  command valid
cmd_rdy  out  1  FIFO can accept; equals !fifo_full
cmd_rd  in  1  1 = readback frame (rd_req), 0 = write frame (wr_req)
cmd_data  in  PMU_CFG_DW  frame word
cmd_flush  in  1  discard all queued (not in-flight) commands
rd_data  out  PMU_CFG_DW  last readback word
rd_data_vld  out  1  1-cycle pulse, rd_data valid
seq_busy  out  1  FSM not IDLE or FIFO not empty
err_timeout  out  1  sticky timeout flag
err_clear  in  1  clears err_timeout
ad5522_rst_busy  in  1  AD5522 power-on calibration still running
pmu_cfg_wr_req  out  1  1-cycle write request to driver
pmu_cfg_rd_req  out  1  1-cycle read request to driver
pmu_cfg_wr_data  out  PMU_CFG_DW  frame word, held stable from req until completion
pmu_cfg_wr_done  in  1  driver write complete
pmu_cfg_rd_done  in  1  driver read complete
pmu_cmp_result  in  PMU_CFG_DW  driver read word
pmu_cmp_result_vld  in  1  driver read word valid

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all outputs 0 except cmd_rdy, which is 1 (FIFO empty). FIFO is emptied and the FSM goes to IDLE.
- Reset mid-transaction: the transaction is abandoned and no rd_data_vld is produced. The driver shares rst.
- Push: occurs when cmd_vld && cmd_rdy. Entry = {cmd_rd, cmd_data}. cmd_vld while full is ignored, nothing is overwritten.
- FSM states: IDLE, ISSUE, WAIT_WR, WAIT_RD, GAP.
- IDLE: if FIFO non-empty and !ad5522_rst_busy, pop the entry and latch it into pmu_cfg_wr_data -> ISSUE. While rst_busy is high, stay in IDLE and do not pop.
- ISSUE: pulse pmu_cfg_wr_req or pmu_cfg_rd_req for exactly 1 cycle, clear the timeout counter, then go to WAIT_WR or WAIT_RD.
- Latency: a push into an empty FIFO in cycle N gives a pop in N+1 and req asserted in N+2.
- WAIT_WR: on pmu_cfg_wr_done -> GAP.
- WAIT_RD: latch rd_done_seen and res_seen independently, in either order or in the same cycle. Capture pmu_cmp_result on vld. When both are seen, drive rd_data and pulse rd_data_vld in the next cycle, then -> GAP.
- Timeout: the counter increments in WAIT_WR/WAIT_RD. On reaching TIMEOUT_CYC-1 without completion, set err_timeout, drop the command (no rd_data_vld) and go -> GAP. A done arriving in the same cycle as the timeout counts as a completion; no error is raised.
- GAP: count GAP_CYC cycles, then -> IDLE.
- err_timeout: sticky. If set and err_clear occur in the same cycle, set wins.
- cmd_flush: empties the FIFO in 1 cycle; an in-flight transaction completes normally. A push in the same cycle as flush is discarded.
- Pop and push in the same cycle: allowed whenever cmd_rdy is high; the count is unchanged.
- pmu_cfg_wr_data changes only on a pop.

Optional Feature:
PMU_CFG_STAT_EN
- Defined: adds outputs stat_wr_cnt[15:0], stat_rd_cnt[15:0] and stat_to_cnt[15:0].
  - stat_wr_cnt increments on each successful write; stat_rd_cnt on each successful read; stat_to_cnt on each timeout.
  - All three saturate at 16'hFFFF and are cleared by rst or err_clear.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pmu_cfg_pkg holds:
  - the FSM state encoding;
  - the FIFO entry layout (op bit at MSB);
  - PMU_CFG_DW default.
- One sub-module, pmu_cfg_fifo: synchronous FWFT FIFO with parameters width and depth, and ports push, pop, flush, full, empty, dout.

Test Plan:
- Write after reset: hold ad5522_rst_busy=1, push write 29'h0A5A5A5. -> No req while busy. After busy falls, a single wr_req pulse with wr_data=29'h0A5A5A5; after wr_done, ≥4 idle cycles before any next req.
- Readback, result first: push rd 29'h1000000; model drives cmp_result_vld with 29'h0400123 two cycles before rd_done. -> rd_data=29'h0400123 and rd_data_vld pulses 1 cycle after rd_done. Repeat with both arriving in the same cycle.
- FIFO full: push 17 commands back-to-back while the driver is stalled. -> cmd_rdy goes low after 16; the 17th is never issued; 16 reqs go out in order.
- Timeout: the driver never returns done. -> err_timeout rises TIMEOUT_CYC cycles after req, the next queued command issues after GAP; err_clear in the same cycle as a second timeout leaves err_timeout=1.
- Flush mid-transfer: queue 5 commands, flush during the first one's WAIT_WR. -> The first completes; no further reqs; seq_busy falls after GAP.
- Reset mid-read: assert rst in WAIT_RD. -> All outputs reach reset values next cycle and no rd_data_vld appears.
